// File: rtl/gemm_operand_packer.sv
// Packs a signed element stream (all of A, then all of B) into lane-packed SRAM words.
// Optional GEMM_PACKER_CHECKSUM_EN adds a running sign-extended sum of accepted elements.
//
// state  | meaning
// IDLE   | waiting for start_i; sizes are checked and latched here
// LOAD_A | packing NumParallelLanes elements per SRAM A word
// LOAD_B | packing NumParallelLanes*NumKernels elements per SRAM B word
module gemm_operand_packer #(
    parameter int InDataWidth      = 8,
    parameter int NumParallelLanes = 4,
    parameter int NumKernels       = 4,
    parameter int SizeAddrWidth    = 8,
    parameter int AddrWidth        = 12
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            start_i,
    input  logic [SizeAddrWidth-1:0]                        M_size_i,
    input  logic [SizeAddrWidth-1:0]                        K_size_i,
    input  logic [SizeAddrWidth-1:0]                        N_size_i,
    input  logic [InDataWidth-1:0]                          in_data_i,
    input  logic                                            in_valid_i,
    output logic                                            in_ready_o,
    output logic [AddrWidth-1:0]                            sram_a_addr_o,
    output logic                                            sram_a_we_o,
    output logic [InDataWidth*NumParallelLanes-1:0]         sram_a_wdata_o,
    output logic [AddrWidth-1:0]                            sram_b_addr_o,
    output logic                                            sram_b_we_o,
    output logic [InDataWidth*NumParallelLanes*NumKernels-1:0] sram_b_wdata_o,
    output logic                                            busy_o,
    output logic                                            done_o,
    output logic                                            err_o
`ifdef GEMM_PACKER_CHECKSUM_EN
    ,
    output logic [31:0]                                     checksum_o
`endif
);

    localparam int BLanes = NumParallelLanes * NumKernels;
    localparam int LaneW  = (BLanes > 1) ? $clog2(BLanes) : 1;
    localparam int AWordW = InDataWidth * NumParallelLanes;
    localparam int BWordW = AWordW * NumKernels;
    localparam int PW     = 2 * SizeAddrWidth;
    localparam logic [PW:0] MaxWords = (PW + 1)'(1) << AddrWidth;

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B} state_t;

    state_t                    r_state;
    logic [PW-1:0]             r_a_words;
    logic [PW-1:0]             r_b_words;
    logic [PW-1:0]             r_word;
    logic [LaneW-1:0]          r_lane;
    logic [BWordW-1:0]         r_pack;
    logic [AddrWidth-1:0]      r_a_addr;
    logic                      r_a_we;
    logic [AWordW-1:0]         r_a_wdata;
    logic [AddrWidth-1:0]      r_b_addr;
    logic                      r_b_we;
    logic [BWordW-1:0]         r_b_wdata;
    logic                      r_done;
    logic                      r_err;

    logic [PW-1:0]             w_mk;
    logic [PW-1:0]             w_kn;
    logic [PW-1:0]             w_a_words;
    logic [PW-1:0]             w_b_words;
    logic                      w_legal;
    logic                      w_accept;
    logic                      w_a_last_lane;
    logic                      w_b_last_lane;
    logic [BWordW-1:0]         w_pack_next;

    assign w_mk      = PW'(M_size_i) * PW'(K_size_i);
    assign w_kn      = PW'(K_size_i) * PW'(N_size_i);
    assign w_a_words = w_mk / PW'(NumParallelLanes);
    assign w_b_words = w_kn / PW'(BLanes);

    // Word-count limits keep every address inside the SRAM with no wrap.
    assign w_legal = (M_size_i != '0) && (K_size_i != '0) && (N_size_i != '0)
                  && ((K_size_i % SizeAddrWidth'(NumParallelLanes)) == '0)
                  && ((N_size_i % SizeAddrWidth'(BLanes)) == '0)
                  && ({1'b0, w_a_words} <= MaxWords)
                  && ({1'b0, w_b_words} <= MaxWords);

    assign in_ready_o    = (r_state != IDLE);
    assign w_accept      = in_valid_i & in_ready_o;
    assign w_a_last_lane = (r_lane == LaneW'(NumParallelLanes - 1));
    assign w_b_last_lane = (r_lane == LaneW'(BLanes - 1));

    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[r_lane*InDataWidth +: InDataWidth] = in_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_a_words <= '0;
            r_b_words <= '0;
            r_word    <= '0;
            r_lane    <= '0;
            r_pack    <= '0;
            r_a_addr  <= '0;
            r_a_we    <= 1'b0;
            r_a_wdata <= '0;
            r_b_addr  <= '0;
            r_b_we    <= 1'b0;
            r_b_wdata <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_a_we <= 1'b0;
            r_b_we <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        if (w_legal) begin
                            r_a_words <= w_a_words;
                            r_b_words <= w_b_words;
                            r_word    <= '0;
                            r_lane    <= '0;
                            r_err     <= 1'b0;
                            r_state   <= LOAD_A;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    if (w_accept) begin
                        r_pack <= w_pack_next;
                        if (w_a_last_lane) begin
                            r_lane    <= '0;
                            r_a_we    <= 1'b1;
                            r_a_addr  <= r_word[AddrWidth-1:0];
                            r_a_wdata <= w_pack_next[AWordW-1:0];
                            if (r_word == r_a_words - 1'b1) begin
                                r_word  <= '0;
                                r_state <= LOAD_B;
                            end else begin
                                r_word <= r_word + 1'b1;
                            end
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_accept) begin
                        r_pack <= w_pack_next;
                        if (w_b_last_lane) begin
                            r_lane    <= '0;
                            r_b_we    <= 1'b1;
                            r_b_addr  <= r_word[AddrWidth-1:0];
                            r_b_wdata <= w_pack_next;
                            if (r_word == r_b_words - 1'b1) begin
                                r_word  <= '0;
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_word <= r_word + 1'b1;
                            end
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef GEMM_PACKER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_checksum <= '0;
        end else if (r_state == IDLE && start_i && w_legal) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + {{(32-InDataWidth){in_data_i[InDataWidth-1]}}, in_data_i};
        end
    end

    assign checksum_o = r_checksum;
`endif

    assign sram_a_addr_o  = r_a_addr;
    assign sram_a_we_o    = r_a_we;
    assign sram_a_wdata_o = r_a_wdata;
    assign sram_b_addr_o  = r_b_addr;
    assign sram_b_we_o    = r_b_we;
    assign sram_b_wdata_o = r_b_wdata;
    assign busy_o         = (r_state != IDLE);
    assign done_o         = r_done;
    assign err_o          = r_err;

endmodule

// File: doc/gemm_operand_packer.md
Name: gemm_operand_packer

Overview:
- Write-side counterpart of the GEMM accelerator's operand read path.
- Accepts a valid/ready byte stream of signed operand elements: all of matrix A, then all of matrix B.
- Packs elements into the lane-packed words the accelerator reads, and writes them into SRAM A (NumParallelLanes elements per word) and SRAM B (NumParallelLanes*NumKernels elements per word).
- Sits between the host/DMA stream and the single-port operand SRAMs; run before start of the GEMM core.

Parameters:
- InDataWidth, 8, element width in bits
- NumParallelLanes, 4, elements per SRAM A word
- NumKernels, 4, SRAM B word holds NumParallelLanes*NumKernels elements
- SizeAddrWidth, 8, width of M/K/N size inputs
- AddrWidth, 12, SRAM word address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- start_i  in  1  begin a load; sizes sampled this cycle
- M_size_i  in  SizeAddrWidth  rows of A
- K_size_i  in  SizeAddrWidth  cols of A / rows of B
- N_size_i  in  SizeAddrWidth  cols of B
- in_data_i  in  InDataWidth  element (A order m-major then k; B order k-major then n)
- in_valid_i  in  1  element valid
- in_ready_o  out  1  packer can accept
- sram_a_addr_o  out  AddrWidth  A word address
- sram_a_we_o  out  1  A write strobe
- sram_a_wdata_o  out  InDataWidth*NumParallelLanes  packed A word
- sram_b_addr_o  out  AddrWidth  B word address
- sram_b_we_o  out  1  B write strobe
- sram_b_wdata_o  out  InDataWidth*NumParallelLanes*NumKernels  packed B word
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  illegal size at last start (sticky)

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0; FSM IDLE; counters and pack registers 0.
- Reset mid-load: reset aborts immediately. Partially packed words are discarded and no write is issued.

FSM: IDLE -> LOAD_A -> LOAD_B -> IDLE.
- IDLE: start_i with legal sizes latches M, K, N and goes to LOAD_A. start_i is ignored when not in IDLE.
- Illegal sizes stay in IDLE and set err_o, which is held until the next legal start_i. Sizes are illegal if any of:
  - any size is 0
  - K mod NumParallelLanes != 0
  - N mod (NumParallelLanes*NumKernels) != 0
  - M*K/NumParallelLanes > 2^AddrWidth
  - K*N/(NumParallelLanes*NumKernels) > 2^AddrWidth
- in_ready_o = 1 in LOAD_A and LOAD_B only (combinational from state). busy_o = (state != IDLE).
- Handshake: an element is accepted on any cycle with in_valid_i & in_ready_o. The lane counter advances per accept; accepted element j of a word lands in bits [j*InDataWidth +: InDataWidth] (lane 0 = LSB).
- Write timing: when the final lane of a word is accepted at cycle t, we = 1 at t+1 for exactly one cycle. addr and wdata are registered with it.
- Word addresses start at 0 per matrix and increment by 1 per write. Between writes, addr holds the last value.
- Transitions:
  - After M*K/NumParallelLanes A words: LOAD_A -> LOAD_B on the accept cycle of the last A element.
  - After K*N/(NumParallelLanes*NumKernels) B words: LOAD_B -> IDLE on the last B accept.
- done_o pulses in the same cycle as the final sram_b_we_o.
- Word counts use 2*SizeAddrWidth-bit products; no wrap is permitted (guarded by the error check).
- A and B writes never coincide.

Optional Feature:
- GEMM_PACKER_CHECKSUM_EN defined: adds output checksum_o [31:0].
  - Cleared on legal start_i.
  - Adds the sign-extended in_data_i on every accept.
  - Valid when done_o = 1; holds until the next start.
- Macro undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then M=4, K=16, N=64, with in_valid_i held high and data = index mod 256 -> 16 A writes at addr 0..15, then 64 B writes at addr 0..63. A word 0 = 0x03020100. done_o pulses exactly once, with the last B write at addr 63.
- Same sizes with in_valid_i toggling 1/0 every cycle -> identical SRAM contents; each we lags its final-lane accept by exactly 1 cycle.
- start_i with K=6 (M=4, N=16) -> err_o = 1, in_ready_o stays 0, no writes. A following legal start clears err_o.
- Second start_i pulse during LOAD_A -> ignored; addresses continue without restart.
- rst_ni low after 3 of 4 lanes of A word 5 -> all outputs 0 asynchronously; no write at addr 5. A new start loads from addr 0.
- Checksum build, M=K=N=16, all elements 0xFF -> checksum_o = 0xFFFFFE00 (-512) at done_o.
